// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 single-precision add/subtract: one operation in flight,
// six-state FSM (IDLE..ROUND), fixed five-edge latency, denormals flushed to zero.
module fp_addsub_seq #(
    parameter logic [31:0] NAN_OUT = 32'h7FC00000
) (
    input  logic        clk_i,
    input  logic        RST,
    input  logic        start_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        fpu_op_i,
    input  logic [1:0]  mode_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result,
    output logic        ine,
    output logic        overflow,
    output logic        underflow,
    output logic        inf,
    output logic        zero
);

    typedef enum logic [2:0] {
        StIdle, StUnpack, StAlign, StAdd, StNorm, StRound
    } state_e;

    state_e            state_q;
    logic [31:0]       opa_q, opb_q, spec_res_q;
    logic              op_q, sign_q, sub_q, zsign_q, spec_q, spec_nan_q, exact_zero_q;
    logic [1:0]        mode_q;
    logic [7:0]        exp_big_q, diff_q;
    logic [23:0]       man_big_q, man_small_q;
    logic [26:0]       small_q, norm_q;
    logic [27:0]       sum_q;
    logic signed [9:0] exp_q;

    logic              sign_a, sign_b, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
    logic              zsign_d, spec_d, spec_nan_d;
    logic [30:0]       mag_a, mag_b;
    logic [31:0]       spec_res_d;

    // Unpack: classify operands, order by magnitude, settle special results early
    always_comb begin
        sign_a     = opa_q[31];
        sign_b     = opb_q[31] ^ op_q;
        a_zero     = opa_q[30:23] == 8'h00;
        b_zero     = opb_q[30:23] == 8'h00;
        a_inf      = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] == 23'h0);
        b_inf      = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] == 23'h0);
        a_nan      = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] != 23'h0);
        b_nan      = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] != 23'h0);
        mag_a      = a_zero ? 31'h0 : opa_q[30:0];
        mag_b      = b_zero ? 31'h0 : opb_q[30:0];
        a_ge       = mag_a >= mag_b;
        zsign_d    = (sign_a == sign_b) ? sign_a : (mode_q == 2'b11);
        spec_d     = 1'b1;
        spec_nan_d = 1'b0;
        spec_res_d = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b))) begin
            spec_nan_d = 1'b1;
            spec_res_d = NAN_OUT;
        end else if (a_inf) begin
            spec_res_d = {sign_a, 31'h7F800000};
        end else if (b_inf) begin
            spec_res_d = {sign_b, 31'h7F800000};
        end else if (a_zero && b_zero) begin
            spec_res_d = {zsign_d, 31'h0};
        end else if (a_zero) begin
            spec_res_d = {sign_b, mag_b};
        end else if (b_zero) begin
            spec_res_d = {sign_a, mag_a};
        end else begin
            spec_d = 1'b0;
        end
    end

    logic [49:0] shifted;
    logic [26:0] small_d;
    logic [27:0] sum_d;

    always_comb begin
        shifted = {man_small_q, 26'h0} >> diff_q;
        small_d = (diff_q >= 8'd26) ? 27'd1 : {shifted[49:24], |shifted[23:0]};
        sum_d   = sub_q ? ({1'b0, man_big_q, 3'b000} - {1'b0, small_q})
                        : ({1'b0, man_big_q, 3'b000} + {1'b0, small_q});
    end

    logic [4:0]        lz;
    logic [26:0]       norm_d;
    logic signed [9:0] exp_norm_d;

    always_comb begin
        lz = '0;
        for (int i = 0; i < 27; i++) begin
            if (sum_q[i]) lz = 5'(26 - i);
        end
        if (sum_q[27]) begin
            norm_d     = {sum_q[27:2], sum_q[1] | sum_q[0]};
            exp_norm_d = $signed({2'b00, exp_big_q}) + 10'sd1;
        end else begin
            norm_d     = sum_q[26:0] << lz;
            exp_norm_d = $signed({2'b00, exp_big_q}) - $signed({5'b00000, lz});
        end
    end

    logic              inexact, inc, inf_sel;
    logic [24:0]       man25;
    logic [22:0]       frac_r;
    logic signed [9:0] exp_r;
    logic [31:0]       res_d;
    logic              ine_d, ovf_d, unf_d;

    // Round: norm_q = {hidden, 23 fraction bits, G, R, S}
    always_comb begin
        inexact = norm_q[2] | norm_q[1] | norm_q[0];
        unique case (mode_q)
            2'b00:   inc = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~sign_q & inexact;
            default: inc = sign_q & inexact;
        endcase
        man25   = {1'b0, norm_q[26:3]} + {24'h0, inc};
        frac_r  = man25[24] ? man25[23:1] : man25[22:0];
        exp_r   = exp_q + $signed({9'h0, man25[24]});
        inf_sel = (mode_q == 2'b00) || (mode_q == 2'b10 && !sign_q) || (mode_q == 2'b11 && sign_q);
        ine_d   = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (spec_q) begin
            res_d = spec_res_q;
        end else if (exact_zero_q) begin
            res_d = {zsign_q, 31'h0};
        end else if (exp_q <= 10'sd0) begin
            res_d = {sign_q, 31'h0};
            unf_d = 1'b1;
            ine_d = 1'b1;
        end else if (exp_r >= 10'sd255) begin
            res_d = inf_sel ? {sign_q, 8'hFF, 23'h0} : {sign_q, 8'hFE, 23'h7FFFFF};
            ovf_d = 1'b1;
            ine_d = 1'b1;
        end else begin
            res_d = {sign_q, exp_r[7:0], frac_r};
            ine_d = inexact;
        end
    end

    always_ff @(posedge clk_i) begin
        if (RST) begin
            state_q   <= StIdle;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            result    <= 32'h0;
            ine       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StUnpack;
                        busy_o  <= 1'b1;
                        opa_q   <= opa_i;
                        opb_q   <= opb_i;
                        op_q    <= fpu_op_i;
                        mode_q  <= mode_i;
                    end
                end
                StUnpack: begin
                    state_q     <= StAlign;
                    spec_q      <= spec_d;
                    spec_nan_q  <= spec_nan_d;
                    spec_res_q  <= spec_res_d;
                    zsign_q     <= zsign_d;
                    sub_q       <= sign_a ^ sign_b;
                    sign_q      <= a_ge ? sign_a : sign_b;
                    exp_big_q   <= a_ge ? mag_a[30:23] : mag_b[30:23];
                    diff_q      <= a_ge ? (mag_a[30:23] - mag_b[30:23])
                                        : (mag_b[30:23] - mag_a[30:23]);
                    man_big_q   <= a_ge ? {1'b1, mag_a[22:0]} : {1'b1, mag_b[22:0]};
                    man_small_q <= a_ge ? {1'b1, mag_b[22:0]} : {1'b1, mag_a[22:0]};
                end
                StAlign: begin
                    state_q <= StAdd;
                    small_q <= small_d;
                end
                StAdd: begin
                    state_q <= StNorm;
                    sum_q   <= sum_d;
                end
                StNorm: begin
                    state_q      <= StRound;
                    norm_q       <= norm_d;
                    exp_q        <= exp_norm_d;
                    exact_zero_q <= sum_q == 28'h0;
                end
                StRound: begin
                    state_q   <= StIdle;
                    busy_o    <= 1'b0;
                    done_o    <= 1'b1;
                    result    <= res_d;
                    ine       <= ine_d;
                    overflow  <= ovf_d;
                    underflow <= unf_d;
                    // NaN results carry no status at all
                    inf       <= !spec_nan_q && (res_d[30:0] == 31'h7F800000);
                    zero      <= !spec_nan_q && (res_d[30:0] == 31'h0);
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 Parameter NAN_OUT, default 32'h7FC00000, the quiet-NaN pattern driven on every invalid or NaN result.
REQ-002 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start_i, input, 1 bit: request strobe, sampled only in IDLE.
REQ-005 Port opa_i, input, 32 bits: IEEE-754 single operand A.
REQ-006 Port opb_i, input, 32 bits: IEEE-754 single operand B.
REQ-007 Port fpu_op_i, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-008 Port mode_i, input, 2 bits: rounding mode; 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
REQ-009 Port busy_o, output, 1 bit: high while an operation is in flight.
REQ-010 Port done_o, output, 1 bit: one-cycle pulse marking a valid result.
REQ-011 Port result, output, 32 bits: rounded sum or difference.
REQ-012 Ports ine, overflow, underflow, inf, zero: outputs, 1 bit each, status flags qualified by done_o.

Function
REQ-013 FSM states SHALL be IDLE, UNPACK, ALIGN, ADD, NORM, ROUND; transitions IDLE->UNPACK on start_i, then one state per cycle, ROUND->IDLE unconditionally.
REQ-014 On the start_i edge the block SHALL register opa_i, opb_i, fpu_op_i and mode_i; later input changes SHALL NOT affect the operation.
REQ-015 Latency SHALL be fixed: start accepted at edge N -> done_o=1 and result/flags valid after edge N+5.
REQ-016 busy_o SHALL be 1 from edge N through edge N+5 inclusive.
REQ-017 start_i asserted while busy_o=1 SHALL be ignored; no queueing.
REQ-018 A new start_i is accepted in the cycle done_o=1 (state back in IDLE), giving back-to-back throughput of one op per 6 cycles.
REQ-019 result and flags SHALL hold their values until the next done_o.
REQ-020 UNPACK: effective sign of B = opb_i[31] XOR fpu_op_i; denormal inputs flushed to signed zero.
REQ-021 ALIGN: the smaller-exponent operand SHALL be right-shifted by the exponent difference, keeping guard, round and sticky bits; a shift of 26 or more collapses that operand to sticky only.
REQ-022 ADD: 28-bit magnitude add or subtract (hidden bit, 23 fraction bits, carry, G/R/S); for subtraction the larger magnitude is the minuend and the result takes its sign.
REQ-023 NORM: a carry-out SHALL cause a right shift by 1 (sticky preserved) and exponent+1; otherwise leading-zero count and left shift, with the exponent decremented by the count.
REQ-024 ROUND: apply mode_i to G/R/S; a mantissa overflow from rounding SHALL renormalise and increment the exponent.
REQ-025 ine SHALL be set when G|R|S is nonzero before rounding.
REQ-026 Exponent >= 255 after rounding: overflow=1 and ine=1; result = signed inf for RNE and for the directed mode matching the sign, otherwise signed max-finite 7F7FFFFF/FF7FFFFF.
REQ-027 Exponent <= 0 after normalisation: result = signed zero, underflow=1, ine=1 (flush to zero).
REQ-028 Exact zero from opposite signs SHALL give +0, or -0 when mode_i=11; (-0)+(-0) SHALL give -0.
REQ-029 A zero operand SHALL pass the other operand through unchanged, with the sign adjusted per REQ-020.
REQ-030 Any NaN input, or inf minus inf of the same magnitude: result = NAN_OUT, all flags 0.
REQ-031 A single inf operand, or inf plus same-sign inf: result = that inf, inf=1.
REQ-032 zero=1 iff result[30:0]==0; inf=1 iff result[30:0]==31'h7F800000.

Reset
REQ-033 When RST=1 at an edge: state=IDLE, busy_o=0, done_o=0, result=32'h0, all flags=0.
REQ-034 RST asserted mid-operation SHALL abort the operation with no done_o pulse; RST has priority over start_i.
REQ-035 The first start_i SHALL be accepted at the first edge with RST=0.

Verification
REQ-036 3F800000 + 3F800000, mode 00, start at edge N -> done_o at edge N+5, result 40000000, all flags 0.
REQ-037 40400000 - 3F800000 -> result 40000000; then 41280000 + C1200000 -> result 3F000000, issued back-to-back with start_i in the done cycle.
REQ-038 46FFFF00 + C6FFFF00 -> result 00000000, zero=1; same operands with mode 11 -> result 80000000.
REQ-039 47C35000 - 3DCCCCCD, mode 00 -> result 47C34FF3, ine=1; 7F7FFFFF + 7F7FFFFF -> result 7F800000, overflow=1, inf=1, ine=1.
REQ-040 7F800000 - 7F800000 -> result 7FC00000; start_i pulsed while busy_o=1 -> ignored, only one done_o.
REQ-041 RST=1 at edge N+2 of an operation -> no done_o, result 0; the next start completes normally.
